// File: rtl/bus_fifo_slave_pkg.sv
// Shared definitions for the bus FIFO slave: the register offsets, the STATUS and CONTROL
// bit positions, and the flag record kept by the top level.
`timescale 1ns/1ps
package bus_fifo_slave_pkg;

    localparam int BUS_DW = 32;
    localparam int ADDR_W = 8;

    // Register offsets; only S_address[4:0] is decoded
    localparam logic [4:0] FIFO_DATA   = 5'h00;
    localparam logic [4:0] FIFO_STATUS = 5'h01;
    localparam logic [4:0] FIFO_CTRL   = 5'h02;
    localparam logic [4:0] FIFO_THR    = 5'h03;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_INT_EN = 1;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } sticky_flags_t;

endpackage

// File: rtl/bus_fifo_slave_if.sv
// Slave-side bus strobes plus the registered read data and interrupt returned by the FIFO.
`timescale 1ns/1ps
interface bus_fifo_slave_if
    import bus_fifo_slave_pkg::*;
;
    logic              S_sel;
    logic              S_wr;
    logic [ADDR_W-1:0] S_address;
    logic [BUS_DW-1:0] S_din;
    logic [BUS_DW-1:0] S_dout;
    logic              irq;

    modport slave  (input S_sel, S_wr, S_address, S_din, output S_dout, irq);
    modport master (output S_sel, S_wr, S_address, S_din, input S_dout, irq);
endinterface

// File: rtl/bus_fifo_slave_fifo_core.sv
// Circular buffer storage: memory, read/write pointers and an occupancy count, with
// push/pop/clear controls. Full pushes and empty pops are ignored here.
`timescale 1ns/1ps
module fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W:0]        count,
    output logic [PTR_W:0]        count_next,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W:0]        count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_next = count_q;
        if (clear)        count_next = '0;
        else if (do_push) count_next = count_q + 1'b1;
        else if (do_pop)  count_next = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_next;
            if (clear) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (do_pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; validity is tracked by the count, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/bus_fifo_slave.sv
// Memory-mapped FIFO peripheral: register decode, CONTROL/THRESHOLD/sticky flags,
// registered read data and a fill-level interrupt around a fifo_core buffer.
`timescale 1ns/1ps
module bus_fifo_slave
    import bus_fifo_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_fifo_slave_if.slave bus
);

    logic [4:0]            offset;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  push;
    logic                  pop;
    logic                  clear;
    logic                  full;
    logic                  empty;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic [DATA_WIDTH-1:0] rdata;

    sticky_flags_t         flags_q, flags_d;
    logic                  int_en_q, int_en_d;
    logic [PTR_W:0]        thr_q, thr_d;
    logic                  irq_d;
    logic [DATA_WIDTH-1:0] rd_value;

    assign offset = bus.S_address[4:0];
    assign wr_acc = bus.S_sel & bus.S_wr;
    assign rd_acc = bus.S_sel & ~bus.S_wr;
    assign push   = wr_acc & (offset == FIFO_DATA);
    assign pop    = rd_acc & (offset == FIFO_DATA);
    assign clear  = wr_acc & (offset == FIFO_CTRL) & bus.S_din[CTRL_CLEAR];

    fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .wdata      (bus.S_din),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .count_next (count_next),
        .rdata      (rdata)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        flags_d  = flags_q;
        int_en_d = int_en_q;
        thr_d    = thr_q;
        if (clear) begin
            flags_d = '0;
        end else begin
            if (push & full)  flags_d.overflow  = 1'b1;
            if (pop  & empty) flags_d.underflow = 1'b1;
        end
        if (wr_acc & (offset == FIFO_CTRL)) int_en_d = bus.S_din[CTRL_INT_EN];
        if (wr_acc & (offset == FIFO_THR))  thr_d    = bus.S_din[PTR_W:0];
    end

    // Interrupt follows the post-edge configuration and fill level
    assign irq_d = int_en_d & (count_next >= thr_d) & (count_next != '0);

    always_comb begin
        rd_value = '0;
        unique case (offset)
            FIFO_DATA: begin
                if (!empty) rd_value = rdata;
            end
            FIFO_STATUS: begin
                rd_value[ST_EMPTY]                  = empty;
                rd_value[ST_FULL]                   = full;
                rd_value[ST_OVERFLOW]               = flags_q.overflow;
                rd_value[ST_UNDERFLOW]              = flags_q.underflow;
                rd_value[ST_COUNT_LSB +: PTR_W + 1] = count;
            end
            FIFO_CTRL: rd_value[CTRL_INT_EN] = int_en_q;
            FIFO_THR:  rd_value[PTR_W:0]     = thr_q;
            default:   rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q    <= '0;
            int_en_q   <= 1'b0;
            thr_q      <= '0;
            bus.S_dout <= '0;
            bus.irq    <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            int_en_q   <= int_en_d;
            thr_q      <= thr_d;
            bus.S_dout <= rd_acc ? rd_value : '0;
            bus.irq    <= irq_d;
        end
    end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Scoreboard bench for bus_fifo_slave: directed scenarios plus random bus traffic checked
// against a queue-based model of the register map.
`timescale 1ns/1ps
module tb_bus_fifo_slave;
    import bus_fifo_slave_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bus_fifo_slave_if bif ();

    bus_fifo_slave #(.DATA_WIDTH(32), .DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    bit          exp_irq = 1'b0;

    // Reference model state
    logic [31:0] m_fifo [$];
    bit          m_ovf, m_udf, m_int_en;
    int unsigned m_thr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf = 0; m_udf = 0; m_int_en = 0; m_thr = 0;
        exp_irq = 0;
    endtask

    task automatic model_access(input bit wr, input logic [4:0] off, input logic [31:0] d,
                                output logic [31:0] rv);
        int sz;
        rv = '0;
        case (off)
            5'h00: begin
                if (wr) begin
                    if (m_fifo.size() == DEPTH) m_ovf = 1;
                    else m_fifo.push_back(d);
                end else begin
                    if (m_fifo.size() == 0) m_udf = 1;
                    else rv = m_fifo.pop_front();
                end
            end
            5'h01: begin
                sz = m_fifo.size();
                if (!wr) rv = (sz << 8) | (int'(m_udf) << 3) | (int'(m_ovf) << 2)
                              | (int'(sz == DEPTH) << 1) | int'(sz == 0);
            end
            5'h02: begin
                if (wr) begin
                    if (d[0]) begin
                        m_fifo.delete();
                        m_ovf = 0;
                        m_udf = 0;
                    end
                    m_int_en = d[1];
                end else rv = {30'b0, m_int_en, 1'b0};
            end
            5'h03: begin
                if (wr) m_thr = d & 32'hF;
                else    rv = m_thr;
            end
            default: rv = '0;
        endcase
        sz = m_fifo.size();
        exp_irq = m_int_en && (sz >= m_thr) && (sz != 0);
    endtask

    // One bus access per call; a read queues either the given constant or the model's value
    task automatic bus(input bit wr, input logic [7:0] addr, input logic [31:0] d,
                       input bit use_const, input logic [31:0] expv);
        logic [31:0] rv;
        @(negedge clk);
        bif.S_sel = 1'b1; bif.S_wr = wr; bif.S_address = addr; bif.S_din = d;
        model_access(wr, addr[4:0], d, rv);
        if (!wr) exp_q.push_back(use_const ? expv : rv);
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] d);
        bus(1'b1, addr, d, 1'b0, '0);
    endtask

    task automatic rd_exp(input logic [7:0] addr, input logic [31:0] expv);
        bus(1'b0, addr, $urandom, 1'b1, expv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bif.S_sel = 1'b0; bif.S_wr = $urandom; bif.S_address = 8'($urandom); bif.S_din = $urandom;
        end
    endtask

    // Monitor: every edge out of reset, compare S_dout and irq against the scoreboard
    always @(posedge clk) begin
        bit was_rd;
        if (reset_n) begin
            was_rd = bif.S_sel & ~bif.S_wr;
            #1;
            if (reset_n) begin
                if (was_rd) begin
                    if (exp_q.size() == 0) check("unexpected_read", 32'h1, 32'h0);
                    else check("read_data", bif.S_dout, exp_q.pop_front());
                end else begin
                    check("idle_dout", bif.S_dout, 32'h0);
                end
                check("irq", {31'b0, bif.irq}, {31'b0, exp_irq});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] hi;
        logic [4:0] off;
        logic [31:0] d;
        bit wr;
        int r;

        bif.S_sel = 0; bif.S_wr = 0; bif.S_address = 0; bif.S_din = 0;
        model_reset();

        // 1 Reset
        #10;
        check("reset_dout", bif.S_dout, 32'h0);
        check("reset_irq", {31'b0, bif.irq}, 32'h0);
        #7 reset_n = 1'b1;
        idle(2);
        rd_exp(8'h01, 32'h0000_0001);
        idle(2);

        // 2 Ordering, through the S1 address window
        wr_reg(8'h20, 32'h11);
        wr_reg(8'h20, 32'h22);
        wr_reg(8'h20, 32'h33);
        rd_exp(8'h21, 32'h0000_0300);
        rd_exp(8'h20, 32'h11);
        rd_exp(8'h20, 32'h22);
        rd_exp(8'h20, 32'h33);
        rd_exp(8'h21, 32'h0000_0001);
        idle(1);

        // 3 Full / overflow
        for (int i = 1; i <= 8; i++) wr_reg(8'h00, i);
        rd_exp(8'h01, 32'h0000_0802);
        wr_reg(8'h00, 32'h9);
        rd_exp(8'h01, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) rd_exp(8'h00, i);

        // 4 Underflow and pointer wrap
        rd_exp(8'h00, 32'h0);
        rd_exp(8'h01, 32'h0000_000D);
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 6; i++) wr_reg(8'h00, 32'hA000_0000 + rnd * 16 + i);
            for (int i = 0; i < 6; i++) rd_exp(8'h00, 32'hA000_0000 + rnd * 16 + i);
        end
        idle(1);

        // 5 Interrupt at threshold
        wr_reg(8'h02, 32'h1);
        wr_reg(8'h03, 32'hFFFF_FFF3);
        rd_exp(8'h03, 32'h3);
        wr_reg(8'h02, 32'h2);
        rd_exp(8'h02, 32'h2);
        wr_reg(8'h00, 32'h51);
        wr_reg(8'h00, 32'h52);
        wr_reg(8'h00, 32'h53);
        idle(1);
        rd_exp(8'h00, 32'h51);
        idle(2);

        // 6 Clear, then reset mid-operation
        wr_reg(8'h02, 32'h1);
        for (int i = 0; i < 5; i++) wr_reg(8'h00, 32'h60 + i);
        wr_reg(8'h02, 32'h3);
        rd_exp(8'h01, 32'h0000_0001);
        wr_reg(8'h03, 32'h1);
        wr_reg(8'h00, 32'h71);
        wr_reg(8'h00, 32'h72);
        rd_exp(8'h00, 32'h71);
        @(posedge clk);
        #3 reset_n = 1'b0;
        bif.S_sel = 1'b0;
        #1;
        check("midop_reset_dout", bif.S_dout, 32'h0);
        check("midop_reset_irq", {31'b0, bif.irq}, 32'h0);
        model_reset();
        #10 reset_n = 1'b1;
        idle(1);
        rd_exp(8'h01, 32'h0000_0001);
        idle(1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                wr = 1'($urandom);
                r  = $urandom_range(0, 9);
                if (r < 4)      off = FIFO_DATA;
                else if (r < 9) off = 5'(r - 4);
                else            off = 5'($urandom_range(5, 31));
                d  = $urandom;
                if (off == FIFO_CTRL && d[4:2] != 3'b000) d[0] = 1'b0;
                hi = 3'($urandom_range(0, 7));
                bus(wr, {hi, off}, d, 1'b0, '0);
            end
        end
        idle(3);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
